mmio_frame_bank: RTL
====================

Name: mmio_frame_bank

Overview:
Memory-mapped peripheral register bank between the processor's data-memory port and the VGA controller. Holds snake segment coordinates, food position, scores and game-over flag. Segment tables are double-buffered: the CPU writes a back buffer, and the VGA sees a front buffer that updates only at frame boundaries after the CPU requests a commit. Parametrised successor to the fixed 100-segment, single-buffer MMIO logic in the top level; adds readback, commit, status and hardware high-score tracking.

Parameters:
MAX_SEG, 100, number of segment entries per axis
COORD_W, 32, stored bits per coordinate entry (wdata truncated to low COORD_W bits)
ADDR_W, 12, decoded address width
X_BASE, 300, first X-table address
Y_BASE, 400, first Y-table address (X_BASE+MAX_SEG <= Y_BASE required)

Ports:
clk  in  1  system clock (25 MHz domain)
reset_n  in  1  synchronous active-low reset
wen  in  1  CPU data-memory write enable
addr  in  ADDR_W  CPU data address
wdata  in  32  CPU write data
dmem_rdata  in  32  RAM read data for unmapped addresses
button_in  in  3  debounced button code
rand_x_in  in  4  LFSR X value
rand_y_in  in  4  LFSR Y value
frame_tick  in  1  one-cycle pulse at start of vertical blank
rdata  out  32  read data returned to CPU
x_values  out  MAX_SEG*COORD_W  front X table, entry i at [i*COORD_W +: COORD_W]
y_values  out  MAX_SEG*COORD_W  front Y table
food_x  out  32  food X
food_y  out  32  food Y
score  out  32  current score
high_score  out  32  high score
game_done  out  1  sticky game-over flag
commit_pending  out  1  commit requested, not yet applied

Behaviour:
- Address map (fixed): 0 button (RO), 1 game_done, 5 clear, 7 rand_x (RO), 8 rand_y (RO), 9 food_x, 10 food_y, 11 status (RO), 12 commit, 14 score, 15 high_score, X_BASE..X_BASE+MAX_SEG-1 X table, Y_BASE..Y_BASE+MAX_SEG-1 Y table.
- Reset (reset_n low at a clk edge): front and back tables all ones (empty sentinel). food_x=5, food_y=5, score=0, high_score=0, game_done=0, commit_pending=0.
- Table write: when wen is high and addr is in a table range, back[addr-base] <= wdata[COORD_W-1:0] on the next edge. Front is unaffected.
- Clear: wen with addr 5 sets every back entry on both axes to all ones in one cycle. Front is unchanged until the next commit.
- Commit: wen with addr 12 sets commit_pending. On any edge where frame_tick=1 and (commit_pending=1 or a commit write occurs that cycle), front <= back (pre-edge values) and commit_pending <= 0. If frame_tick=1 and no commit is pending, front holds.
- Any table write or clear coincident with an applied commit lands in back only. Front receives the old back value.
- Repeated commit writes before a tick collapse into one commit.
- Score: writing addr 14 sets score to wdata. high_score is updated on the same edge to wdata if wdata > high_score (unsigned). Writing addr 15 sets high_score directly and takes priority over the auto-update.
- game_done: a write to addr 1 with wdata[0]=1 sets it. It is cleared only by reset; writes with wdata[0]=0 are ignored.
- Food registers take a full 32-bit write.
- rdata is combinational:
  - addr 0 → {29'b0, button_in}
  - addr 1 → {31'b0, game_done}
  - addr 7/8 → zero-extended rand_x_in/rand_y_in
  - addr 9/10 → food_x/food_y
  - addr 11 → {31'b0, commit_pending}
  - addr 14/15 → score/high_score
  - table ranges → zero-extended back entry
  - otherwise → dmem_rdata
- All mapped outputs are registered; latency from write edge to output is 1 cycle. For the front tables, latency is up to one frame.
- Outputs hold their values when wen=0.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles → x_values/y_values all ones, food 5/5, score 0, high 0, game_done 0, commit_pending 0.
- Write X[3]=7 (addr 303), Y[3]=9 (addr 403), no commit → front entry 3 still all ones, rdata@303=7. Write addr 12, then pulse frame_tick → commit_pending=1 until the tick; after the tick, front[3]=7/9 and commit_pending=0.
- Same-cycle commit write with frame_tick: pre-load X[0]=2 earlier, then write addr 12 with frame_tick=1 → front[0]=2, commit_pending=0 next cycle.
- Clear then commit: front holds data, write addr 5, then commit+tick → front all ones. Before the tick, front still holds the old data.
- Score: write 10, then 4, then 12 to addr 14 → high_score 10, 10, 12. Write 3 to addr 15 → high_score=3.
- game_done sticky: write 1 to addr 1, then 0 → game_done stays 1. Pulse reset_n low → game_done=0. Reads of addr 0, 7 and 500 return the button, rand_x and dmem_rdata passthrough respectively.

Source files
------------

// File: rtl/mmio_frame_bank.sv
// Memory-mapped register bank shared by the CPU and the VGA controller.
// The CPU writes the back segment tables; VGA reads front tables that are swapped in at frame ticks.
module mmio_frame_bank #(
    parameter int MAX_SEG = 100,
    parameter int COORD_W = 32,
    parameter int ADDR_W  = 12,
    parameter int X_BASE  = 300,
    parameter int Y_BASE  = 400
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wen,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [31:0]                wdata,
    input  logic [31:0]                dmem_rdata,
    input  logic [2:0]                 button_in,
    input  logic [3:0]                 rand_x_in,
    input  logic [3:0]                 rand_y_in,
    input  logic                       frame_tick,
    output logic [31:0]                rdata,
    output logic [MAX_SEG*COORD_W-1:0] x_values,
    output logic [MAX_SEG*COORD_W-1:0] y_values,
    output logic [31:0]                food_x,
    output logic [31:0]                food_y,
    output logic [31:0]                score,
    output logic [31:0]                high_score,
    output logic                       game_done,
    output logic                       commit_pending
);

    localparam int SEG_IW = (MAX_SEG > 1) ? $clog2(MAX_SEG) : 1;

    localparam logic [ADDR_W-1:0] A_BUTTON = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_DONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CLEAR  = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_RANDX  = ADDR_W'(7);
    localparam logic [ADDR_W-1:0] A_RANDY  = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] A_FOODX  = ADDR_W'(9);
    localparam logic [ADDR_W-1:0] A_FOODY  = ADDR_W'(10);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(11);
    localparam logic [ADDR_W-1:0] A_COMMIT = ADDR_W'(12);
    localparam logic [ADDR_W-1:0] A_SCORE  = ADDR_W'(14);
    localparam logic [ADDR_W-1:0] A_HIGH   = ADDR_W'(15);
    localparam logic [ADDR_W-1:0] X_LO     = ADDR_W'(X_BASE);
    localparam logic [ADDR_W-1:0] X_HI     = ADDR_W'(X_BASE + MAX_SEG);
    localparam logic [ADDR_W-1:0] Y_LO     = ADDR_W'(Y_BASE);
    localparam logic [ADDR_W-1:0] Y_HI     = ADDR_W'(Y_BASE + MAX_SEG);

    logic [COORD_W-1:0] r_back_x  [MAX_SEG];
    logic [COORD_W-1:0] r_back_y  [MAX_SEG];
    logic [COORD_W-1:0] r_front_x [MAX_SEG];
    logic [COORD_W-1:0] r_front_y [MAX_SEG];
    logic [31:0]        r_food_x, r_food_y, r_score, r_high;
    logic               r_done, r_commit_pending;

    logic              w_in_x, w_in_y, w_commit_wr, w_commit_apply;
    logic [SEG_IW-1:0] w_x_idx, w_y_idx;

    assign w_in_x         = (addr >= X_LO) && (addr < X_HI);
    assign w_in_y         = (addr >= Y_LO) && (addr < Y_HI);
    assign w_x_idx        = SEG_IW'(addr - X_LO);
    assign w_y_idx        = SEG_IW'(addr - Y_LO);
    assign w_commit_wr    = wen && (addr == A_COMMIT);
    // A commit written in the same cycle as the tick is applied immediately.
    assign w_commit_apply = frame_tick && (r_commit_pending || w_commit_wr);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the tables are reset because all-ones is the empty-segment sentinel the VGA relies on.
            for (int i = 0; i < MAX_SEG; i++) begin
                r_back_x[i]  <= '1;
                r_back_y[i]  <= '1;
                r_front_x[i] <= '1;
                r_front_y[i] <= '1;
            end
            r_food_x         <= 32'd5;
            r_food_y         <= 32'd5;
            r_score          <= '0;
            r_high           <= '0;
            r_done           <= 1'b0;
            r_commit_pending <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let front capture the pre-edge back even when back is written this cycle.
            if (w_commit_apply) begin
                for (int i = 0; i < MAX_SEG; i++) begin
                    r_front_x[i] <= r_back_x[i];
                    r_front_y[i] <= r_back_y[i];
                end
                r_commit_pending <= 1'b0;
            end else if (w_commit_wr) begin
                r_commit_pending <= 1'b1;
            end

            if (wen) begin
                if (addr == A_CLEAR) begin
                    for (int i = 0; i < MAX_SEG; i++) begin
                        r_back_x[i] <= '1;
                        r_back_y[i] <= '1;
                    end
                end
                if (w_in_x) r_back_x[w_x_idx] <= wdata[COORD_W-1:0];
                if (w_in_y) r_back_y[w_y_idx] <= wdata[COORD_W-1:0];
                if (addr == A_FOODX) r_food_x <= wdata;
                if (addr == A_FOODY) r_food_y <= wdata;
                if (addr == A_DONE && wdata[0]) r_done <= 1'b1;
                if (addr == A_SCORE) begin
                    r_score <= wdata;
                    if (wdata > r_high) r_high <= wdata;
                end
                if (addr == A_HIGH) r_high <= wdata;
            end
        end
    end

    always_comb begin
        // NOTE: rdata gets a default before the case so no path leaves it unassigned (no latch).
        rdata = dmem_rdata;
        if (w_in_x) begin
            rdata = 32'(r_back_x[w_x_idx]);
        end else if (w_in_y) begin
            rdata = 32'(r_back_y[w_y_idx]);
        end else begin
            case (addr)
                A_BUTTON: rdata = {29'b0, button_in};
                A_DONE:   rdata = {31'b0, r_done};
                A_RANDX:  rdata = {28'b0, rand_x_in};
                A_RANDY:  rdata = {28'b0, rand_y_in};
                A_FOODX:  rdata = r_food_x;
                A_FOODY:  rdata = r_food_y;
                A_STATUS: rdata = {31'b0, r_commit_pending};
                A_SCORE:  rdata = r_score;
                A_HIGH:   rdata = r_high;
                default:  rdata = dmem_rdata;
            endcase
        end
    end

    for (genvar g = 0; g < MAX_SEG; g++) begin : g_pack
        assign x_values[g*COORD_W +: COORD_W] = r_front_x[g];
        assign y_values[g*COORD_W +: COORD_W] = r_front_y[g];
    end

    assign food_x         = r_food_x;
    assign food_y         = r_food_y;
    assign score          = r_score;
    assign high_score     = r_high;
    assign game_done      = r_done;
    assign commit_pending = r_commit_pending;

endmodule
